// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a checksummed program image into instruction memory
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    byte stream: N[15:8], N[7:0], 4*N data bytes MSB first, XOR checksum
//   in_ready            byte accepted this cycle (low only once the image is verified)
//   imem_we/addr/wdata  one-cycle registered write of each assembled word
//   cpu_rst             holds the CPU in reset until a verified image is loaded
//   done, error         image verified / header or checksum error (sticky until rst)
//   words_loaded        number of words written so far
module imem_loader #(
   parameter int WIDTH    = 32,
   parameter int MEM_SIZE = 1024,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WIDTH-1:0]  imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, RUN, ERR} state_t;
   localparam logic [15:0] MAX_N = 16'(MEM_SIZE);
   state_t           state, state_nx;
   logic [15:0]      n;
   logic [1:0]       byte_idx;
   logic [WIDTH-9:0] shreg;
   logic [7:0]       csum;
   logic             acc;
   logic [15:0]      n_full;
   assign acc    = in_valid && in_ready;
   assign n_full = {n[15:8], in_data};
   always_ff @(posedge clk)
      state <= rst ? HDR_HI : state_nx;
   // words_loaded doubles as the index of the word being assembled
   always_comb begin
      state_nx = state;
      if (acc)
         case (state)
            HDR_HI: state_nx = HDR_LO;
            HDR_LO: state_nx = n_full > MAX_N ? ERR : n_full == 16'd0 ? CHK : DATA;
            DATA:   state_nx = byte_idx == 2'd3 && words_loaded + 16'd1 == n ? CHK : DATA;
            CHK:    state_nx = in_data == csum ? RUN : ERR;
            default: state_nx = state;
         endcase
   end
   always_comb begin
      in_ready = state != RUN;
      cpu_rst  = state != RUN;
      done     = state == RUN;
      error    = state == ERR;
   end
   always_ff @(posedge clk)
      if (rst) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
         n            <= '0;
         byte_idx     <= '0;
         shreg        <= '0;
         csum         <= '0;
      end else begin
         imem_we <= 1'b0;
         if (acc && state == HDR_HI) n[15:8] <= in_data;
         if (acc && state == HDR_LO) n[7:0] <= in_data;
         if (acc && state == DATA) begin
            shreg    <= {shreg[WIDTH-17:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               imem_we      <= 1'b1;
               imem_addr    <= words_loaded[ADDR_W-1:0];
               imem_wdata   <= {shreg, in_data};
               words_loaded <= words_loaded + 16'd1;
            end
         end
      end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;
   logic        clk = 0, rst = 1, in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, imem_we, cpu_rst, done, error;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [15:0] words_loaded;
   int total = 0, bad = 0;
   logic [41:0] got_w[$], exp_w[$];
   int          exp_st, exp_words;
   imem_loader dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded));
   always #5 clk = ~clk;
   always @(negedge clk) if (imem_we) got_w.push_back({imem_addr, imem_wdata});
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // exp_st: 0 still loading, 1 verified, 2 error
   function automatic void model(input logic [7:0] s[$]);
      int nw, cs, len;
      exp_w.delete(); exp_st = 0; exp_words = 0; len = s.size();
      if (len < 2) return;
      nw = {s[0], s[1]};
      if (nw > 1024) begin exp_st = 2; return; end
      cs = 0;
      for (int w = 0; w < nw; w++) begin
         if (len < 6 + 4 * w) return;
         exp_w.push_back({10'(w), s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
         cs = cs ^ s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
         exp_words++;
      end
      if (len < 3 + 4 * nw) return;
      exp_st = s[2+4*nw] == 8'(cs) ? 1 : 2;
   endfunction
   task automatic do_reset();
      @(negedge clk); rst = 1; in_valid = 0;
      @(negedge clk); rst = 0;
      got_w.delete();
      chk("rst_ready", in_ready, 1); chk("rst_cpu_rst", cpu_rst, 1); chk("rst_done", done, 0);
      chk("rst_error", error, 0); chk("rst_words", words_loaded, 0); chk("rst_we", imem_we, 0);
   endtask
   task automatic send(input logic [7:0] s[$], input int max_idle);
      foreach (s[i]) begin
         repeat ($urandom_range(max_idle)) begin @(negedge clk); in_valid = 0; in_data = 8'($urandom); end
         @(negedge clk); in_valid = 1; in_data = s[i];
      end
      @(negedge clk); in_valid = 0;
   endtask
   task automatic check_result(input string tag);
      repeat (2) @(negedge clk);
      chk({tag, "_nwr"}, got_w.size(), exp_w.size());
      foreach (exp_w[i]) if (i < got_w.size()) chk({tag, "_wr"}, got_w[i], exp_w[i]);
      chk({tag, "_done"}, done, exp_st == 1);
      chk({tag, "_error"}, error, exp_st == 2);
      chk({tag, "_cpu_rst"}, cpu_rst, exp_st != 1);
      chk({tag, "_ready"}, in_ready, exp_st != 1);
      chk({tag, "_words"}, words_loaded, exp_words);
   endtask
   task automatic run(input string tag, input logic [7:0] s[$], input int max_idle);
      do_reset();
      model(s);
      send(s, max_idle);
      check_result(tag);
   endtask
   initial begin
      logic [7:0] t1[$], s[$];
      int n;
      t1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
      run("t1", t1, 0);
      do_reset();
      send('{8'h00, 8'h00, 8'h00}, 0);
      chk("t2_done_next", done, 1); chk("t2_cpu_rst_next", cpu_rst, 0);
      model('{8'h00, 8'h00, 8'h00});
      check_result("t2");
      s = t1; s[10] = 8'h2B;
      run("t3", s, 0);
      s.push_back(8'h55); s.push_back(8'hAA); s.push_back(8'h00);
      model(s);
      send('{8'h55, 8'hAA, 8'h00}, 1);
      check_result("t3_extra");
      do_reset();
      send('{8'h04, 8'h01}, 0);
      chk("t4_err_next", error, 1);
      model('{8'h04, 8'h01});
      check_result("t4");
      run("t5", t1, 3);
      do_reset();
      send(t1[0:4], 1);
      @(negedge clk); in_valid = 1; in_data = t1[5]; rst = 1;
      @(negedge clk); rst = 0; in_valid = 0;
      chk("t6_words_rst", words_loaded, 0);
      @(negedge clk);
      chk("t6_no_write", got_w.size(), 0);
      model(t1);
      send(t1, 0);
      check_result("t6");
      s.delete(); s.push_back(8'h04); s.push_back(8'h00);
      n = 0;
      for (int i = 0; i < 4096; i++) begin s.push_back(8'($urandom)); n = n ^ s[s.size()-1]; end
      s.push_back(8'(n));
      run("max_n", s, 0);
      for (int k = 0; k < 12; k++) begin
         n = $urandom_range(5);
         s.delete(); s.push_back(8'h00); s.push_back(8'(n));
         for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
         s.push_back($urandom_range(3) == 0 ? 8'($urandom) : 8'h00);
         if (s[s.size()-1] == 8'h00) begin
            s[s.size()-1] = 8'h00;
            for (int i = 2; i < 2 + 4 * n; i++) s[s.size()-1] = s[s.size()-1] ^ s[i];
         end
         run("rand", s, 2);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
